cfg_chain_arbiter: RTL and testbench

//  Shares the fabric configuration chain (col_sel / cfg_out_start / cfg_bit_out /
//  cfg_bit_out_valid) between two serial config sources: req 0 = Wishbone config

---
 rtl/cfg_chain_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_cfg_chain_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cfg_chain_arbiter.sv
// cfg_chain_arbiter
//   Shares the fabric configuration chain between two serial config sources
//   (r0 = Wishbone config loader, r1 = boot/scan loader). A requester is granted
//   a whole column frame of TILE_CFG_SIZE*MY bits. Bits are never interleaved, and
//   a round-robin pointer arbitrates when both sources request. The chain is
//   driven through one register stage.
//   Optional watchdog: define CFG_ARB_TIMEOUT_EN to abort frames that stall for
//   TIMEOUT_CYC consecutive cycles without owner valid.
//
//   Handshake: rN_req is raised and held for the whole frame. rN_gnt rises one
//   cycle after the request is sampled in IDLE. While rN_gnt is high, the owner's
//   start/bit/valid appear on the chain one cycle later. gnt is the only
//   qualifier, so owner inputs after gnt falls are ignored.
//   state_dbg exposes the FSM state (IDLE=0, OWN=1, GAP=2).
module cfg_chain_arbiter #(
  parameter int TILE_CFG_SIZE = 256,
  parameter int MX = 4,
  parameter int MY = 4
`ifdef CFG_ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = 1024
`endif
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic       r0_req,
  input  logic [3:0] r0_col_sel,
  input  logic       r0_start,
  input  logic       r0_bit,
  input  logic       r0_valid,
  input  logic       r1_req,
  input  logic [3:0] r1_col_sel,
  input  logic       r1_start,
  input  logic       r1_bit,
  input  logic       r1_valid,
  output logic       r0_gnt,
  output logic       r1_gnt,
  output logic [3:0] col_sel,
  output logic       cfg_out_start,
  output logic       cfg_bit_out,
  output logic       cfg_bit_out_valid,
  output logic       busy,
  output logic       frame_done,
  output logic       frame_abort,
  output logic       timeout,
  output logic [1:0] state_dbg
);

  localparam int FRAME_BITS = TILE_CFG_SIZE * MY;
  localparam int CNT_W = $clog2(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_BITS);

  typedef enum logic [1:0] {IDLE = 2'd0, OWN = 2'd1, GAP = 2'd2} state_t;

  state_t           state, state_d;
  logic             owner, owner_d;      // 0 = r0 holds the chain, 1 = r1
  logic             prio_r1, prio_r1_d;  // 1: r1 wins a tie
  logic [CNT_W-1:0] bit_cnt, bit_cnt_d, cnt_next;
  logic             r0_gnt_d, r1_gnt_d;
  logic [3:0]       col_sel_d;
  logic             start_d, bit_d, valid_d, done_d, abort_d;
  logic             pick_r1, own_req, own_start, own_bit, own_valid, last_bit;
  logic             stall;

  assign busy      = (state != IDLE);
  assign state_dbg = state;

  // Tie-break goes to the requester not served last.
  assign pick_r1   = r1_req && (!r0_req || prio_r1);
  assign own_req   = owner ? r1_req   : r0_req;
  assign own_start = owner ? r1_start : r0_start;
  assign own_bit   = owner ? r1_bit   : r0_bit;
  assign own_valid = owner ? r1_valid : r0_valid;
  // A start pulse restarts the count; a start with valid counts as bit #1.
  assign cnt_next  = (own_start ? '0 : bit_cnt) + CNT_W'(own_valid);
  assign last_bit  = own_valid && (cnt_next == LAST_CNT);

`ifdef CFG_ARB_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(TIMEOUT_CYC);

  logic [IDLE_W-1:0] idle_cnt, idle_cnt_d, idle_inc;
  logic              timeout_q;

  assign idle_inc = idle_cnt + IDLE_W'(1);
  assign stall    = (state == OWN) && !own_valid && (idle_inc == IDLE_LIMIT);
  assign timeout  = timeout_q;

  // Count consecutive owner-silent cycles; clear on any valid or when leaving OWN.
  always_comb begin
    idle_cnt_d = '0;
    if (state == OWN && state_d == OWN && !own_valid) idle_cnt_d = idle_inc;
  end

  // Watchdog counter and the one-cycle timeout pulse.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      idle_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      idle_cnt  <= idle_cnt_d;
      timeout_q <= stall;
    end
  end
`else
  assign stall   = 1'b0;
  assign timeout = 1'b0;
`endif

  // Next-state and next-output logic; chain outputs default to 0 outside OWN.
  always_comb begin
    state_d   = state;
    owner_d   = owner;
    prio_r1_d = prio_r1;
    bit_cnt_d = bit_cnt;
    r0_gnt_d  = r0_gnt;
    r1_gnt_d  = r1_gnt;
    col_sel_d = col_sel;
    start_d   = 1'b0;
    bit_d     = 1'b0;
    valid_d   = 1'b0;
    done_d    = 1'b0;
    abort_d   = 1'b0;
    case (state)
      IDLE: begin
        if (r0_req || r1_req) begin
          state_d   = OWN;
          owner_d   = pick_r1;
          r0_gnt_d  = !pick_r1;
          r1_gnt_d  = pick_r1;
          col_sel_d = pick_r1 ? r1_col_sel : r0_col_sel;
          bit_cnt_d = '0;
        end
      end
      OWN: begin
        if (last_bit) begin
          // Final bit is forwarded even if req drops at the same edge.
          start_d   = own_start;
          bit_d     = own_bit;
          valid_d   = 1'b1;
          bit_cnt_d = cnt_next;
          done_d    = 1'b1;
          r0_gnt_d  = 1'b0;
          r1_gnt_d  = 1'b0;
          state_d   = GAP;
        end else if (!own_req || stall) begin
          abort_d   = 1'b1;
          r0_gnt_d  = 1'b0;
          r1_gnt_d  = 1'b0;
          state_d   = GAP;
        end else begin
          start_d   = own_start;
          bit_d     = own_bit;
          valid_d   = own_valid;
          bit_cnt_d = cnt_next;
        end
      end
      GAP: begin
        prio_r1_d = !owner;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) state <= IDLE;
    else           state <= state_d;
  end

  // Grant, column, counter and registered chain outputs.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      owner             <= 1'b0;
      prio_r1           <= 1'b0;
      bit_cnt           <= '0;
      r0_gnt            <= 1'b0;
      r1_gnt            <= 1'b0;
      col_sel           <= 4'd0;
      cfg_out_start     <= 1'b0;
      cfg_bit_out       <= 1'b0;
      cfg_bit_out_valid <= 1'b0;
      frame_done        <= 1'b0;
      frame_abort       <= 1'b0;
    end else begin
      owner             <= owner_d;
      prio_r1           <= prio_r1_d;
      bit_cnt           <= bit_cnt_d;
      r0_gnt            <= r0_gnt_d;
      r1_gnt            <= r1_gnt_d;
      col_sel           <= col_sel_d;
      cfg_out_start     <= start_d;
      cfg_bit_out       <= bit_d;
      cfg_bit_out_valid <= valid_d;
      frame_done        <= done_d;
      frame_abort       <= abort_d;
    end
  end

  // Grants are one-hot or zero, and a granted column is inside the fabric.
  assert property (@(posedge wb_clk_i) disable iff (!wb_rst_i) !(r0_gnt && r1_gnt));
  assert property (@(posedge wb_clk_i) disable iff (!wb_rst_i)
                   !(r0_gnt || r1_gnt) || ({28'd0, col_sel} < 32'(MX)));

endmodule

// File: tb/tb_cfg_chain_arbiter.sv
// Testbench for cfg_chain_arbiter: directed scenario sequence with randomized
// frame contents, checked against a frame-level reference model (what the owner
// drove must appear on the chain one cycle later, and the frame must end on bit 1024).
module tb_cfg_chain_arbiter;

  localparam int FRAME_BITS = 1024;

  logic       clk, rst_n;
  logic       r0_req, r0_start, r0_bit, r0_valid;
  logic [3:0] r0_col_sel;
  logic       r1_req, r1_start, r1_bit, r1_valid;
  logic [3:0] r1_col_sel;
  logic       r0_gnt, r1_gnt;
  logic [3:0] col_sel;
  logic       cfg_out_start, cfg_bit_out, cfg_bit_out_valid;
  logic       busy, frame_done, frame_abort, timeout;
  logic [1:0] state_dbg;

  int n_checks = 0;
  int n_pass   = 0;
  logic [2:0] exp_q[$];

  cfg_chain_arbiter #(
    .TILE_CFG_SIZE(256),
    .MX(4),
    .MY(4)
`ifdef CFG_ARB_TIMEOUT_EN
    ,
    .TIMEOUT_CYC(16)
`endif
  ) dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst_n),
    .r0_req(r0_req),
    .r0_col_sel(r0_col_sel),
    .r0_start(r0_start),
    .r0_bit(r0_bit),
    .r0_valid(r0_valid),
    .r1_req(r1_req),
    .r1_col_sel(r1_col_sel),
    .r1_start(r1_start),
    .r1_bit(r1_bit),
    .r1_valid(r1_valid),
    .r0_gnt(r0_gnt),
    .r1_gnt(r1_gnt),
    .col_sel(col_sel),
    .cfg_out_start(cfg_out_start),
    .cfg_bit_out(cfg_bit_out),
    .cfg_bit_out_valid(cfg_bit_out_valid),
    .busy(busy),
    .frame_done(frame_done),
    .frame_abort(frame_abort),
    .timeout(timeout),
    .state_dbg(state_dbg)
  );

  // Clock and global run limit.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL global_timeout: simulation did not finish, checks passed %0d of %0d", n_pass, n_checks);
    $fatal(1, "run limit reached");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic clear_inputs();
    r0_req = 0; r0_col_sel = 0; r0_start = 0; r0_bit = 0; r0_valid = 0;
    r1_req = 0; r1_col_sel = 0; r1_start = 0; r1_bit = 0; r1_valid = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 0;
    tick();
    rst_n = 1;
  endtask

  task automatic drive_src(input int who, input logic s, input logic b, input logic v);
    if (who == 0) begin r0_start = s; r0_bit = b; r0_valid = v; end
    else          begin r1_start = s; r1_bit = b; r1_valid = v; end
  endtask

  task automatic drive_noise(input int who);
    drive_src(who, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  task automatic set_req(input int who, input logic r);
    if (who == 0) r0_req = r; else r1_req = r;
  endtask

  function automatic logic gnt_of(input int who);
    return (who == 0) ? r0_gnt : r1_gnt;
  endfunction

  // Owner streams randomly gapped bits while the other source emits noise.
  // drop_at: owner lowers req after that many counted bits (abort expected).
  // hold_at: return mid-frame after that many counted bits.
  // restart_at: issue a second start pulse (with valid) at that count.
  // stall_at/stall_len: force a run of invalid cycles at that count.
  task automatic run_frame(input int who, input int drop_at, input int hold_at,
                           input int restart_at, input int stall_at,
                           input int stall_len, input bit use_start);
    int sent, mism, cyc, stall_left;
    bit finished, restarted, stalled;
    logic s, b, v;
    logic [2:0] exp_v;
    sent = 0; mism = 0; cyc = 0; stall_left = 0;
    finished = 0; restarted = 0; stalled = 0;
    exp_q.delete();
    while (!finished && cyc < 4000) begin
      cyc++;
      drive_noise(1 - who);
      if (hold_at >= 0 && sent == hold_at) begin
        finished = 1;
      end else if (drop_at >= 0 && sent == drop_at) begin
        set_req(who, 1'b0);
        drive_src(who, 1'b0, 1'($urandom_range(0, 1)), 1'b1);
        tick();
        check("abort_pulse", frame_abort, 1);
        check("abort_no_done", frame_done, 0);
        check("abort_gnt", gnt_of(who), 0);
        check("abort_chain_quiet", {cfg_out_start, cfg_bit_out, cfg_bit_out_valid}, 0);
        finished = 1;
      end else begin
        if (stall_at >= 0 && !stalled && sent == stall_at) begin
          stalled = 1;
          stall_left = stall_len;
        end
        v = (stall_left > 0) ? 1'b0 : ($urandom_range(0, 3) != 0);
        if (stall_left > 0) stall_left--;
        b = 1'($urandom_range(0, 1));
        s = 1'b0;
        if (v && use_start && sent == 0) s = 1'b1;
        if (v && restart_at >= 0 && !restarted && sent == restart_at) begin
          s = 1'b1;
          restarted = 1;
        end
        drive_src(who, s, b, v);
        exp_q.push_back({s, b, v});
        if (v) sent = s ? 1 : sent + 1;
        tick();
        exp_v = exp_q.pop_front();
        if ({cfg_out_start, cfg_bit_out, cfg_bit_out_valid} !== exp_v) mism++;
        if (sent == FRAME_BITS) begin
          check("done_pulse", frame_done, 1);
          check("done_gnt", gnt_of(who), 0);
          check("done_no_abort", frame_abort, 0);
          check("done_busy_gap", busy, 1);
          finished = 1;
        end else if (frame_done || frame_abort || timeout || gnt_of(who) !== 1'b1) begin
          mism++;
        end
      end
    end
    check("frame_mirror", mism, 0);
    check("frame_finished", finished, 1);
    drive_src(who, 1'b0, 1'b0, 1'b0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int quiet;
    int early;
    clear_inputs();
    rst_n = 0;
    tick();

    // Reset state.
    check("rst_gnt", {r0_gnt, r1_gnt}, 0);
    check("rst_col", col_sel, 0);
    check("rst_chain", {cfg_out_start, cfg_bit_out, cfg_bit_out_valid}, 0);
    check("rst_busy", busy, 0);
    check("rst_pulses", {frame_done, frame_abort, timeout}, 0);
    check("rst_state", state_dbg, 0);
    rst_n = 1;
    tick();
    check("idle_no_req", busy, 0);

    // r0 alone on column 2, r1 toggling its data lines without requesting.
    r0_col_sel = 4'd2;
    r0_req = 1;
    check("s1_pre_gnt", r0_gnt, 0);
    tick();
    check("s1_gnt_latency", r0_gnt, 1);
    check("s1_no_r1_gnt", r1_gnt, 0);
    check("s1_col", col_sel, 2);
    check("s1_busy", busy, 1);
    run_frame(0, -1, -1, -1, -1, 0, 1);
    r0_req = 0;
    drive_src(1, 1'b0, 1'b0, 1'b0);
    tick();
    check("s1_back_idle", busy, 0);
    check("s1_gap_chain", {cfg_out_start, cfg_bit_out, cfg_bit_out_valid}, 0);
    check("s1_done_once", frame_done, 0);
    check("s1_col_hold", col_sel, 2);

    // Both request after reset: r0 first, then round-robin.
    do_reset();
    r0_col_sel = 4'd1;
    r1_col_sel = 4'd3;
    r0_req = 1;
    r1_req = 1;
    tick();
    check("s2_r0_first", {r0_gnt, r1_gnt}, 2'b10);
    check("s2_col_r0", col_sel, 1);
    run_frame(0, -1, -1, -1, -1, 0, 1);
    drive_src(1, 1'b0, 1'b0, 1'b0);
    tick();
    check("s2_gap_no_gnt", {r0_gnt, r1_gnt}, 0);
    tick();
    check("s2_rr_r1", {r0_gnt, r1_gnt}, 2'b01);
    check("s2_col_r1", col_sel, 3);
    run_frame(1, -1, -1, 300, -1, 0, 1);
    drive_src(0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    check("s2_rr_back_r0", {r0_gnt, r1_gnt}, 2'b10);
    check("s2_col_back", col_sel, 1);

    // r1 drops req after 300 bits, then keeps toggling valid.
    do_reset();
    r1_col_sel = 4'd0;
    r1_req = 1;
    tick();
    check("s3_gnt", {r0_gnt, r1_gnt}, 2'b01);
    run_frame(1, 300, -1, -1, -1, 0, 1);
    quiet = 0;
    for (int i = 0; i < 6; i++) begin
      drive_src(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
      tick();
      if (cfg_bit_out_valid || cfg_out_start || r1_gnt || frame_abort) quiet++;
    end
    check("s3_no_bits_after_drop", quiet, 0);
    check("s3_idle", busy, 0);
    // New frame without a start pulse must still count from 0.
    drive_src(1, 1'b0, 1'b0, 1'b0);
    r1_req = 1;
    tick();
    check("s3_regrant", r1_gnt, 1);
    run_frame(1, -1, -1, -1, -1, 0, 0);
    r1_req = 0;
    tick();

    // Reset mid-frame at bit 500.
    do_reset();
    r0_col_sel = 4'd3;
    r0_req = 1;
    tick();
    check("s4_gnt", r0_gnt, 1);
    run_frame(0, -1, 500, -1, -1, 0, 1);
    drive_src(0, 1'b1, 1'b1, 1'b1);
    #3;
    rst_n = 0;
    #1;
    check("s4_async_gnt", {r0_gnt, r1_gnt}, 0);
    check("s4_async_col", col_sel, 0);
    check("s4_async_chain", {cfg_out_start, cfg_bit_out, cfg_bit_out_valid}, 0);
    check("s4_async_busy", busy, 0);
    tick();
    clear_inputs();
    rst_n = 1;
    r1_col_sel = 4'd1;
    r1_req = 1;
    tick();
    check("s4_r1_gnt", {r0_gnt, r1_gnt}, 2'b01);
    check("s4_r1_col", col_sel, 1);
    run_frame(1, -1, -1, -1, -1, 0, 0);
    r1_req = 0;
    tick();

`ifdef CFG_ARB_TIMEOUT_EN
    // Watchdog: 16 consecutive silent cycles abort the frame.
    do_reset();
    r0_req = 1;
    tick();
    check("to_gnt", r0_gnt, 1);
    run_frame(0, -1, 5, -1, -1, 0, 1);
    early = 0;
    for (int i = 1; i <= 15; i++) begin
      drive_src(0, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
      tick();
      if (frame_abort || timeout || !r0_gnt) early++;
    end
    check("to_no_early", early, 0);
    drive_src(0, 1'b0, 1'b0, 1'b0);
    tick();
    check("to_timeout", timeout, 1);
    check("to_abort", frame_abort, 1);
    check("to_gnt_drop", r0_gnt, 0);
    check("to_no_done", frame_done, 0);
    tick();
    check("to_pulse_once", {timeout, frame_abort}, 0);
`else
    // Without the watchdog a long stall never aborts the frame.
    do_reset();
    r0_req = 1;
    tick();
    check("stall_gnt", r0_gnt, 1);
    run_frame(0, -1, -1, -1, 200, 40, 1);
    early = 0;
    check("stall_no_timeout", timeout, early);
    r0_req = 0;
    tick();
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
